// File: rtl/rtc_init_sequencer.sv
// rtc_init_sequencer
// Walks the RTC initialisation ROM from index 0 and issues each byte as a
// multiplexed address/data write to the external RTC. It stops at the 8'hFF
// terminator or after index 15, whichever comes first.
// Optional build macro: RTC_INIT_READBACK_EN adds a read-back cycle after
// every write. A mismatch sets the sticky err flag.
// Without the macro, rd_n is tied high, err is tied low and bus_in is ignored.
module rtc_init_sequencer #(
   parameter logic [7:0] ADDR_BASE = 8'h00,
   parameter int         T_SETUP   = 1,
   parameter int         T_PULSE   = 2,
   parameter int         T_HOLD    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       cs_n,
   output logic       a_d,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Phase counter reload values: a phase ends when the counter reads zero.
   localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
   localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
   localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_A_SETUP,
      S_A_PULSE,
      S_A_HOLD,
      S_D_SETUP,
      S_D_PULSE,
      S_D_HOLD,
`ifdef RTC_INIT_READBACK_EN
      S_R_SETUP,
      S_R_PULSE,
      S_R_HOLD,
`endif
      S_NEXT,
      S_DONE
   } state_t;

   state_t     state_reg;
   logic [7:0] cnt_reg;
   logic [7:0] data_reg;

`ifndef RTC_INIT_READBACK_EN
   // Without read-back there is no read strobe and no error source.
   logic unused_bus_in;
   assign unused_bus_in = ^bus_in;
   assign rd_n = 1'b1;
   assign err  = 1'b0;
`endif

   // Sequencer FSM. Every output is registered and is changed only on a state
   // transition, so each pin holds its value for a whole phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         data_reg  <= '0;
         rom_addr  <= '0;
         cs_n      <= 1'b1;
         wr_n      <= 1'b1;
         a_d       <= 1'b0;
         bus_oe    <= 1'b0;
         bus_out   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef RTC_INIT_READBACK_EN
         rd_n      <= 1'b1;
         err       <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_reg <= S_FETCH;
                  rom_addr  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
`ifdef RTC_INIT_READBACK_EN
                  err       <= 1'b0;
`endif
               end
            end
            S_FETCH: begin
               if (rom_data == 8'hFF) begin
                  state_reg <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  data_reg  <= rom_data;
                  state_reg <= S_A_SETUP;
                  cnt_reg   <= LD_SETUP;
                  cs_n      <= 1'b0;
                  a_d       <= 1'b0;
                  bus_oe    <= 1'b1;
                  bus_out   <= ADDR_BASE + {4'h0, rom_addr};
               end
            end
            S_A_SETUP, S_D_SETUP: begin
               if (cnt_reg == 8'd0) begin
                  state_reg <= (state_reg == S_A_SETUP) ? S_A_PULSE : S_D_PULSE;
                  cnt_reg   <= LD_PULSE;
                  wr_n      <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_A_PULSE, S_D_PULSE: begin
               if (cnt_reg == 8'd0) begin
                  state_reg <= (state_reg == S_A_PULSE) ? S_A_HOLD : S_D_HOLD;
                  cnt_reg   <= LD_HOLD;
                  wr_n      <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_A_HOLD: begin
               if (cnt_reg == 8'd0) begin
                  state_reg <= S_D_SETUP;
                  cnt_reg   <= LD_SETUP;
                  a_d       <= 1'b1;
                  bus_out   <= data_reg;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_D_HOLD: begin
               if (cnt_reg == 8'd0) begin
`ifdef RTC_INIT_READBACK_EN
                  // Release the bus but keep the chip selected for read-back.
                  state_reg <= S_R_SETUP;
                  cnt_reg   <= LD_SETUP;
                  bus_oe    <= 1'b0;
`else
                  state_reg <= S_NEXT;
                  cs_n      <= 1'b1;
                  bus_oe    <= 1'b0;
`endif
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
`ifdef RTC_INIT_READBACK_EN
            S_R_SETUP: begin
               if (cnt_reg == 8'd0) begin
                  state_reg <= S_R_PULSE;
                  cnt_reg   <= LD_PULSE;
                  rd_n      <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_R_PULSE: begin
               if (cnt_reg == 8'd0) begin
                  // The RTC output is sampled at the end of the last strobe cycle.
                  state_reg <= S_R_HOLD;
                  cnt_reg   <= LD_HOLD;
                  rd_n      <= 1'b1;
                  if (bus_in != data_reg) begin
                     err <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_R_HOLD: begin
               if (cnt_reg == 8'd0) begin
                  state_reg <= S_NEXT;
                  cs_n      <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
`endif
            S_NEXT: begin
               // Index 15 is the last entry: finish instead of wrapping to 0.
               if (rom_addr == 4'hF) begin
                  state_reg <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  rom_addr  <= rom_addr + 4'd1;
                  state_reg <= S_FETCH;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               cs_n      <= 1'b1;
               wr_n      <= 1'b1;
               bus_oe    <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
